// File: rtl/mmcm_drp_reconfig.sv
// DRP initiator: holds an MMCM in reset, read-modify-writes one of two register
// tables through the DRP port, releases reset and waits for LOCKED.
module mmcm_drp_reconfig #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter logic [NUM_ENTRIES*39-1:0] CFG0_TABLE = '0,
  parameter logic [NUM_ENTRIES*39-1:0] CFG1_TABLE = '0,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mmcm_rst,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  output logic [15:0] di,
  input  logic [15:0] do_in,
  input  logic        drdy,
  input  logic        locked
);

  localparam int unsigned ENTRY_W = 39;
  localparam int unsigned IDX_W   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned TMR_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [TMR_W-1:0] DRDY_LAST = TMR_W'(DRDY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, ASSERT_RST, READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE, WAIT_LOCK, DONE, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_sel;
  logic               sel_q, sel_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [6:0]         daddr_d;
  logic [15:0]        di_d;
  logic               busy_d, done_d, error_d, mmcm_rst_d, den_d, dwe_d;
  logic               lock_meta, lock_sync;
  logic [ENTRY_W-1:0] entry;
  logic [6:0]         e_addr;
  logic [15:0]        e_mask, e_data;

  // Table entry for the register about to be addressed (NEXT looks one ahead).
  assign idx_sel = (state_q == NEXT) ? idx_q + IDX_W'(1) : idx_q;

  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (idx_sel == IDX_W'(i)) begin
        entry = sel_q ? CFG1_TABLE[ENTRY_W*i +: ENTRY_W] : CFG0_TABLE[ENTRY_W*i +: ENTRY_W];
      end
    end
  end

  assign e_addr = entry[38:32];
  assign e_mask = entry[31:16];
  assign e_data = entry[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sel_q     <= 1'b0;
      tmr_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mmcm_rst  <= 1'b0;
      daddr     <= '0;
      den       <= 1'b0;
      dwe       <= 1'b0;
      di        <= '0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      tmr_q     <= tmr_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      mmcm_rst  <= mmcm_rst_d;
      daddr     <= daddr_d;
      den       <= den_d;
      dwe       <= dwe_d;
      di        <= di_d;
      lock_meta <= locked;
      lock_sync <= lock_meta;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    tmr_d   = tmr_q;
    daddr_d = daddr;
    di_d    = di;
    error_d = error;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ASSERT_RST;
          sel_d   = sel;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
      ASSERT_RST: begin
        state_d = READ;
        daddr_d = e_addr;
      end
      READ: begin
        tmr_d   = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (drdy) begin
          state_d = WRITE;
          di_d    = (do_in & e_mask) | (e_data & ~e_mask);
        end else if (tmr_q == DRDY_LAST) begin
          state_d = ERROR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      WRITE: begin
        tmr_d   = '0;
        state_d = WAIT_WR;
      end
      WAIT_WR: begin
        if (drdy) begin
          state_d = NEXT;
        end else if (tmr_q == DRDY_LAST) begin
          state_d = ERROR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = RELEASE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          daddr_d = e_addr;
          state_d = READ;
        end
      end
      RELEASE: begin
        tmr_d   = '0;
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = DONE;
        end else if (tmr_q == LOCK_LAST) begin
          state_d = ERROR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ERROR) error_d = 1'b1;
    busy_d     = !(state_d inside {IDLE, DONE, ERROR});
    done_d     = (state_d == DONE);
    mmcm_rst_d = state_d inside {ASSERT_RST, READ, WAIT_RD, WRITE, WAIT_WR, NEXT};
    den_d      = (state_d == READ) || (state_d == WRITE);
    dwe_d      = (state_d == WRITE);
  end

endmodule

// File: doc/mmcm_drp_reconfig.md
Name: mmcm_drp_reconfig

Overview:
- DRP initiator that reprograms an MMCM_ADV at run time. It drives the DADDR/DEN/DWE/DI port side that the clock generator currently ties off.
- On a start pulse it performs these steps in order:
  - holds the MMCM in reset;
  - read-modify-writes a table of DRP registers, choosing one of two parameterised configurations;
  - releases reset;
  - waits for LOCKED.
- Runs in the free-running DRP clock domain, beside the clock generator in the top level.

Parameters:
- NUM_ENTRIES, 8: DRP registers per configuration, 1..16.
- CFG0_TABLE, all zeros: configuration 0. NUM_ENTRIES*39 bits; entry i occupies bits [39*i+38 : 39*i] as {addr[6:0], mask[15:0], data[15:0]}.
- CFG1_TABLE, all zeros: configuration 1, same layout.
- DRDY_TIMEOUT, 64: maximum cycles from the DEN pulse to DRDY before an error is flagged.
- LOCK_TIMEOUT, 65535: maximum cycles from reset release to LOCKED before an error is flagged.

Ports:
- clk  in  1  DRP clock; also DCLK of the MMCM.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- sel  in  1  configuration select (0 = CFG0_TABLE, 1 = CFG1_TABLE); captured when start is accepted.
- busy  out  1  high from start acceptance until DONE or ERROR is entered.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky flag; cleared by the next accepted start or by rst.
- mmcm_rst  out  1  drives the MMCM RST pin.
- daddr  out  7  DRP address.
- den  out  1  DRP enable; one-cycle pulse.
- dwe  out  1  DRP write enable; asserted only together with den.
- di  out  16  DRP write data.
- do_in  in  16  DRP read data; valid when drdy is high.
- drdy  in  1  DRP ready.
- locked  in  1  MMCM LOCKED; asynchronous, double-flopped internally.

Behaviour:
- Reset values: busy=0, done=0, error=0, mmcm_rst=0, daddr=0, den=0, dwe=0, di=0. The FSM goes to IDLE and the entry index is 0.
- States: IDLE, ASSERT_RST, READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE, WAIT_LOCK, DONE, ERROR.
- IDLE:
  - start=1 → ASSERT_RST on the next edge.
  - Captures sel, sets index=0, clears error, sets busy=1.
- ASSERT_RST: mmcm_rst=1 from this cycle until RELEASE. Unconditionally → READ.
- READ:
  - daddr = addr[index], den=1, dwe=0 for exactly one cycle.
  - Clears the timeout counter; → WAIT_RD.
- WAIT_RD:
  - On drdy=1, latch rdata=do_in; → WRITE.
  - If the counter reaches DRDY_TIMEOUT → ERROR.
  - drdy asserted in the same cycle as den is not legal per the DRP protocol and is ignored.
- WRITE:
  - di = (rdata & mask) | (data & ~mask). Mask bit 1 means keep the existing bit.
  - den=1, dwe=1, daddr unchanged, for one cycle; → WAIT_WR.
- WAIT_WR: same drdy/timeout rules as WAIT_RD; on drdy → NEXT.
- NEXT:
  - If index == NUM_ENTRIES-1 → RELEASE.
  - Otherwise index+1 → READ.
  - Index width is clog2(NUM_ENTRIES) with a minimum of 1; it never wraps.
- RELEASE:
  - mmcm_rst=0.
  - Clears the lock counter; → WAIT_LOCK.
- WAIT_LOCK:
  - Synchronised locked=1 → DONE.
  - If the counter reaches LOCK_TIMEOUT → ERROR.
- DONE: done=1 for one cycle, busy=0; → IDLE.
- ERROR:
  - error=1, busy=0, mmcm_rst=0.
  - den and dwe forced to 0; → IDLE.
- Signal holding:
  - daddr and di hold their value from the den pulse until drdy is seen.
  - den is never asserted while a transaction is outstanding.
- start while busy: ignored, no queuing.
- rst mid-sequence:
  - All outputs return to their reset values in the following cycle, including mmcm_rst=0.
  - A partially written MMCM is left as is; the next start reprograms it completely.
- Latency: a successful run takes 3 + NUM_ENTRIES × (4 + rd_wait + wr_wait) + 1 + lock_wait + 1 cycles.

Test Plan:
- Basic reprogram:
  - Stimulus: NUM_ENTRIES=2, DRP model with 3-cycle drdy latency, reg 0x08 initial 0x1041, entry {0x08, 0xF000, 0x0186}, start with sel=0.
  - Expected: read of 0x08, then write of di=0x1186 with dwe=1; mmcm_rst held high throughout both entries; done pulses after locked rises; busy spans exactly from acceptance to done.
- Configuration select:
  - Stimulus: run with sel=1, where CFG1_TABLE differs in the data field of every entry.
  - Expected: every written di matches the CFG1 merge; no CFG0 address appears on daddr.
- DRDY timeout:
  - Stimulus: DRP model never returns drdy for the second read.
  - Expected: after 64 wait cycles, error=1, done never pulses, mmcm_rst=0, den stays 0 thereafter.
- Lock timeout and recovery:
  - Stimulus: hold locked=0 with LOCK_TIMEOUT=100; then issue start again with locked working.
  - Expected: first run sets error after 100 cycles; the second start clears error and completes with done.
- Protocol stress:
  - Stimulus: assert start during busy; DRP model with drdy latency of 1 cycle then 40 cycles.
  - Expected: second start ignored; exactly 2×NUM_ENTRIES den pulses; daddr and di stable while each transaction is outstanding.
- Reset mid-write:
  - Stimulus: assert rst during WAIT_WR, then issue start.
  - Expected: next cycle all outputs are 0 and state is IDLE; a fresh start completes the full table.
